// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM state encodings and
// the helper used to size the chunk counter.
package serial_chunk_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef logic [1:0] state_t;

    // Counter width for n chunks; never narrower than one bit so NCH==1 still works.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_rca.sv
// Combinational CHUNK-bit ripple-carry slice built from one-bit full adders.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module serial_chunk_adder_rca #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Area-lean WIDTH-bit add/subtract that pushes CHUNK bits per clock through one
// reused ripple slice, with valid/ready handshakes on both operands and result.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH:0]    sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk, slice_s;
    logic              slice_cout, slice_c_msb;
    logic              last_chunk;

    assign in_ready   = (state_q == ST_IDLE) & ~rst;
    assign last_chunk = (count_q == CW'(NCH - 1));

    // Operand chunk select driven by the counter; operands stay put after latching.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (count_q == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    serial_chunk_adder_rca #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    // Subtraction is a + ~b + ~cin, so invert b and the carry up front.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                carry_d = slice_cout;
                count_d = count_q + CW'(1);
                for (int i = 0; i < NCH; i++) begin
                    if (count_q == CW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = slice_s;
                    end
                end
                if (last_chunk) begin
                    sum_d[WIDTH] = slice_cout;
                    ovf_d        = slice_c_msb ^ slice_cout;
                    out_valid_d  = 1'b1;
                    count_d      = '0;
                    state_d      = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: three adders (CHUNK 4, 1, 16) against a plain-arithmetic
// reference, with vector tables plus backpressure, reset and operand-toggle sequences.
module tb_serial_chunk_adder;

    logic        clk;
    logic        rst;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [16:0] sum_w     [3];
    logic        ovf_w     [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            serial_chunk_adder #(
                .WIDTH (16),
                .CHUNK ((gi == 0) ? 4 : ((gi == 1) ? 1 : 16))
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .a         (a),
                .b         (b),
                .cin       (cin),
                .sub       (sub),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .sum       (sum_w[gi]),
                .ovf       (ovf_w[gi])
            );
        end
    endgenerate

    function automatic int nch_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
    endfunction

    // Reference: unsigned and signed arithmetic on integers, {ovf, sum17}.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        int ua, ub, sa, sb, ci, us, ss;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        ci = c ? 1 : 0;
        if (!s) begin
            us = ua + ub + ci;
            ss = sa + sb + ci;
        end else begin
            us = ua - ub - ci + 65536;
            ss = sa - sb - ci;
        end
        return {(ss > 32767) || (ss < -32768), us[16:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Run one operation on DUT k up to out_valid; optionally scramble ports during RUN.
    task automatic do_op(input int k, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic ts, input bit toggle,
                         output logic [16:0] rs, output logic ro, output int lat);
        int waitc;
        a = ta; b = tb_; cin = tc; sub = ts;
        in_valid[k] = 1'b1;
        waitc = 0;
        while (!in_ready[k] && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (waitc >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            if (toggle) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) chk("out_valid_timeout", 32'd0, 32'd1);
        rs = sum_w[k];
        ro = ovf_w[k];
        $display("op dut%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h ovf=%0d lat=%0d",
                 k, ta, tb_, tc, ts, rs, ro, lat);
    endtask

    task automatic release_result(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("handoff_out_valid_low", {31'd0, out_valid[k]}, 32'd0);
        chk("handoff_in_ready_high", {31'd0, in_ready[k]}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic        vsub;
        logic [16:0] esum;
        logic        eovf;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [16:0] rs;
        logic        ro;
        int          lat;
        logic [17:0] exp;
        logic [16:0] held;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h0_8000, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0_FFFD, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h1_7FFF, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 17'h0_FFFF, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1_FFFF, 1'b0};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0_5555, 1'b0};

        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready[0]}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("reset_sum", {15'd0, sum_w[0]}, 32'd0);
        chk("reset_ovf", {31'd0, ovf_w[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", {31'd0, in_ready[0]}, 32'd1);

        // Table vectors on the CHUNK=4 instance.
        for (int i = 0; i < 8; i++) begin
            do_op(0, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, 1'b0, rs, ro, lat);
            chk("vec_sum", {15'd0, rs}, {15'd0, vecs[i].esum});
            chk("vec_ovf", {31'd0, ro}, {31'd0, vecs[i].eovf});
            chk("vec_latency", lat, 4);
            release_result(0);
        end

        // Case 1 on CHUNK=1 and CHUNK=16 instances.
        for (int k = 1; k < 3; k++) begin
            do_op(k, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, rs, ro, lat);
            chk("c1_sum", {15'd0, rs}, 32'h0001_0000);
            chk("c1_ovf", {31'd0, ro}, 32'd0);
            chk("c1_latency", lat, nch_of(k));
            release_result(k);
        end

        // Backpressure: result and flags must hold while out_ready is low.
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, rs, ro, lat);
        held = rs;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_sum_stable", {15'd0, sum_w[0]}, {15'd0, held});
            chk("bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
        end
        release_result(0);

        // Reset during the second RUN cycle discards the operation.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rst_no_pulse", {31'd0, out_valid[0]}, 32'd0);
        end
        chk("rst_after_in_ready", {31'd0, in_ready[0]}, 32'd1);
        do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, rs, ro, lat);
        chk("rst_next_sum", {15'd0, rs}, 32'h0000_5555);
        release_result(0);

        // Random operands with ports scrambled during RUN, across all instances.
        for (int i = 0; i < 30; i++) begin
            int          k;
            logic [15:0] ra, rb;
            logic        rc, rsb;
            k   = i % 3;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            rsb = 1'($urandom);
            exp = model(ra, rb, rc, rsb);
            do_op(k, ra, rb, rc, rsb, 1'b1, rs, ro, lat);
            chk("rnd_sum", {15'd0, rs}, {15'd0, exp[16:0]});
            chk("rnd_ovf", {31'd0, ro}, {31'd0, exp[17]});
            chk("rnd_latency", lat, nch_of(k));
            release_result(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
